// File: rtl/mem_pkg.sv
// mem_pkg: shared definitions for the MEM-stage data-memory access controller.
//   - access size codes used on the size port and in the lane aligner
//   - FSM state encoding of mem_stall_ctrl (also visible on its dbgState port)
//   - isAligned(): alignment rule shared by the controller
package mem_pkg;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        LOAD_WAIT  = 2'd1,
        STORE_WAIT = 2'd2,
        DONE       = 2'd3
    } memState_e;

    // Bytes are always aligned, halves need an even address, words (and the
    // reserved size, which behaves as a word) need a multiple of four.
    function automatic logic isAligned(input logic [1:0] sz, input logic [1:0] off);
        case (sz)
            SZ_B:    isAligned = 1'b1;
            SZ_H:    isAligned = ~off[0];
            default: isAligned = (off == 2'b00);
        endcase
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align: purely combinational byte-lane handling for a 32-bit bus.
//   Store side (driven from the live MEM-stage request):
//     size, byteOff, storeData -> byteEn (4 lane enables), storeRep (replicated data)
//   Load side (driven from the latched request and the returned word):
//     loadSize, loadOff, loadUns, readWord -> loadData (lane-selected, extended)
module mem_lane_align
    import mem_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  byteOff,
    input  logic [31:0] storeData,
    output logic [3:0]  byteEn,
    output logic [31:0] storeRep,
    input  logic [1:0]  loadSize,
    input  logic [1:0]  loadOff,
    input  logic        loadUns,
    input  logic [31:0] readWord,
    output logic [31:0] loadData
);

    logic [31:0] laneWord;

    always_comb begin
        byteEn   = 4'b1111;
        storeRep = storeData;
        case (size)
            SZ_B: begin
                byteEn   = 4'b0001 << byteOff;
                storeRep = {4{storeData[7:0]}};
            end
            SZ_H: begin
                byteEn   = 4'b0011 << {byteOff[1], 1'b0};
                storeRep = {2{storeData[15:0]}};
            end
            default: ;
        endcase
    end

    // Shift the addressed lane down to bit 0; a half access only ever has an
    // offset of 0 or 2 here because misaligned requests never reach memory.
    always_comb begin
        laneWord = readWord >> {loadOff, 3'b000};
        case (loadSize)
            SZ_B:    loadData = {{24{~loadUns & laneWord[7]}},  laneWord[7:0]};
            SZ_H:    loadData = {{16{~loadUns & laneWord[15]}}, laneWord[15:0]};
            default: loadData = readWord;
        endcase
    end

endmodule

// File: rtl/mem_stall_ctrl.sv
// mem_stall_ctrl: MEM-stage data-memory access controller.
//   Pipeline side: mem_read/mem_write/size/uns/addr/wdata in; stall_load,
//   stall_store (combinational), rdata/rdata_valid and err (registered) out.
//   Memory side: dm_req/dm_we/dm_addr/dm_be/dm_wdata out, dm_ack/dm_rdata in.
//   Debug: dbgState exposes the FSM state.
//
// Memory handshake: dm_req rises with dm_we/dm_addr/dm_be/dm_wdata and all of
// them stay stable until the memory answers with a single-cycle dm_ack
// (dm_rdata is valid only in that cycle). dm_req drops on the edge after the
// ack, or after TIMEOUT wait cycles without one; any dm_ack seen while no
// request is outstanding is ignored.
module mem_stall_ctrl
    import mem_pkg::*;
#(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          mem_read,
    input  logic          mem_write,
    input  logic [1:0]    size,
    input  logic          uns,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic          stall_load,
    output logic          stall_store,
    output logic [DW-1:0] rdata,
    output logic          rdata_valid,
    output logic          err,
    output logic          dm_req,
    output logic          dm_we,
    output logic [AW-1:0] dm_addr,
    output logic [3:0]    dm_be,
    output logic [DW-1:0] dm_wdata,
    input  logic          dm_ack,
    input  logic [DW-1:0] dm_rdata,
    output logic [1:0]    dbgState
);

    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

    memState_e   state;
    logic [CW-1:0] toCnt;
    logic [1:0]  lSize;
    logic [1:0]  lOff;
    logic        lUns;
    logic        curAligned;
    logic [3:0]  alignBe;
    logic [31:0] alignWdata;
    logic [31:0] loadData;

    mem_lane_align uAlign (
        .size      (size),
        .byteOff   (addr[1:0]),
        .storeData (wdata),
        .byteEn    (alignBe),
        .storeRep  (alignWdata),
        .loadSize  (lSize),
        .loadOff   (lOff),
        .loadUns   (lUns),
        .readWord  (dm_rdata),
        .loadData  (loadData)
    );

    assign curAligned = isAligned(size, addr[1:0]);
    assign dbgState   = state;

    // Stalls must rise in the same cycle the access shows up in IDLE, so they
    // are decoded from state plus live inputs. Gating with rst_n keeps them low
    // while reset is held even if the pipeline still presents an access.
    assign stall_load  = rst_n & (((state == IDLE) & mem_read & curAligned)
                                  | (state == LOAD_WAIT));
    assign stall_store = rst_n & (((state == IDLE) & mem_write & ~mem_read & curAligned)
                                  | (state == STORE_WAIT));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            dm_req      <= 1'b0;
            dm_we       <= 1'b0;
            dm_addr     <= '0;
            dm_be       <= '0;
            dm_wdata    <= '0;
            rdata       <= '0;
            rdata_valid <= 1'b0;
            err         <= 1'b0;
            toCnt       <= '0;
            lSize       <= SZ_B;
            lOff        <= 2'b00;
            lUns        <= 1'b0;
        end else begin
            err         <= 1'b0;
            rdata_valid <= 1'b0;
            case (state)
                IDLE: begin
                    // A load wins over a simultaneous store; the store is dropped.
                    if (mem_read) begin
                        if (curAligned) begin
                            state   <= LOAD_WAIT;
                            dm_req  <= 1'b1;
                            dm_we   <= 1'b0;
                            dm_addr <= {addr[AW-1:2], 2'b00};
                            dm_be   <= alignBe;
                            lSize   <= size;
                            lOff    <= addr[1:0];
                            lUns    <= uns;
                            toCnt   <= '0;
                        end else begin
                            err         <= 1'b1;
                            rdata       <= '0;
                            rdata_valid <= 1'b1;
                        end
                    end else if (mem_write) begin
                        if (curAligned) begin
                            state    <= STORE_WAIT;
                            dm_req   <= 1'b1;
                            dm_we    <= 1'b1;
                            dm_addr  <= {addr[AW-1:2], 2'b00};
                            dm_be    <= alignBe;
                            dm_wdata <= alignWdata;
                            toCnt    <= '0;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                LOAD_WAIT, STORE_WAIT: begin
                    if (dm_ack) begin
                        state  <= DONE;
                        dm_req <= 1'b0;
                        dm_we  <= 1'b0;
                        if (state == LOAD_WAIT) begin
                            rdata       <= loadData;
                            rdata_valid <= 1'b1;
                        end
                    end else if (toCnt == TO_LAST) begin
                        // Bus error: abandon the request; a late ack lands in
                        // DONE or IDLE where it has no effect.
                        state  <= DONE;
                        dm_req <= 1'b0;
                        dm_we  <= 1'b0;
                        err    <= 1'b1;
                        if (state == LOAD_WAIT) begin
                            rdata       <= '0;
                            rdata_valid <= 1'b1;
                        end
                    end else begin
                        toCnt <= toCnt + CW'(1);
                    end
                end
                // mem_read/mem_write still belong to the finished instruction.
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/mem_stall_ctrl.md
Name: mem_stall_ctrl

Overview:
- MEM-stage data-memory access controller; the producer of the load/store stall requests that the pipeline stall unit converts into its 6-bit stall vector.
- Issues a req/ack handshake to a variable-latency data memory and holds stall_load/stall_store high until the access completes.
- Returns aligned, sign- or zero-extended load data, and flags misaligned accesses and bus timeouts.

Parameters:
- AW, 32, address width
- DW, 32, data width (fixed at 32; byte lanes are 4)
- TIMEOUT, 16, max cycles to wait for mem_ack before a bus error (at least 2)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- mem_read  in  1  MEM-stage instruction is a load
- mem_write  in  1  MEM-stage instruction is a store
- size  in  2  00 byte, 01 half, 10 word, 11 reserved (treated as word)
- uns  in  1  zero-extend load data (LBU/LHU)
- addr  in  AW  byte address
- wdata  in  DW  store data, right-justified
- stall_load  out  1  load in progress, freeze pipeline
- stall_store  out  1  store in progress, freeze pipeline
- rdata  out  DW  extended load result
- rdata_valid  out  1  rdata valid this cycle
- err  out  1  one-cycle pulse: misaligned access or timeout
- dm_req  out  1  memory request, held until ack
- dm_we  out  1  write strobe
- dm_addr  out  AW  word-aligned address ({addr[AW-1:2],2'b00})
- dm_be  out  4  byte enables
- dm_wdata  out  DW  lane-replicated store data
- dm_ack  in  1  memory completion, one cycle
- dm_rdata  in  DW  read word, valid with dm_ack

Behaviour:
- Reset values (async, rst_n=0): state IDLE, dm_req=0, dm_we=0, dm_be=0, dm_addr=0, dm_wdata=0, rdata=0, rdata_valid=0, err=0, timeout counter=0. stall_load and stall_store evaluate to 0.
- States: IDLE, LOAD_WAIT, STORE_WAIT, DONE.
- IDLE:
  - If mem_read and aligned: latch addr, size, uns; dm_req=1, dm_we=0; go to LOAD_WAIT.
  - Else if mem_write and aligned: also latch wdata; dm_req=1, dm_we=1; go to STORE_WAIT.
  - mem_read has priority when both are high; the store is dropped.
- Alignment rule: a half access needs addr[0]=0; a word access needs addr[1:0]=0. A misaligned access issues no request, pulses err for 1 cycle, does not stall, and returns rdata=0 with rdata_valid=1 for a load.
- Stall outputs are combinational, so the pipeline freezes in the same cycle the access appears:
  - stall_load = (IDLE & mem_read & aligned) | LOAD_WAIT.
  - stall_store = (IDLE & mem_write & !mem_read & aligned) | STORE_WAIT.
- LOAD_WAIT / STORE_WAIT:
  - dm_* outputs hold stable until dm_ack.
  - On dm_ack: dm_req=0 at the next edge; go to DONE. For a load, register the extended rdata and set rdata_valid=1 for the DONE cycle.
- Minimum latency: request in cycle 0, ack in cycle 1 earliest, DONE in cycle 2, pipeline advances at the end of cycle 2.
- Timeout: the counter clears on entering a WAIT state and increments each WAIT cycle without ack. When it reaches TIMEOUT-1 with no ack: err=1 in DONE, rdata=0, dm_req dropped. A late dm_ack arriving after this is ignored.
- DONE: one cycle, both stalls 0, mem_read/mem_write ignored because they still belong to the completed instruction. Next state is always IDLE.
- Back-to-back accesses therefore cost at least 3 cycles each.
- Byte enables:
  - byte: be = 4'b0001 << addr[1:0]
  - half: be = 4'b0011 << {addr[1],1'b0}
  - word: be = 4'b1111
- Store data: dm_wdata = byte replicated x4, half replicated x2, or the word.
- Load extraction: select the lane by the latched addr[1:0]. Sign-extend from bit 7 or bit 15 unless uns=1.
- Reset mid-access: everything returns to reset values immediately and the in-flight transaction is abandoned. A dm_ack arriving in IDLE is ignored.

Decomposition:
- Shared package mem_pkg: the size codes (SZ_B=2'b00, SZ_H=2'b01, SZ_W=2'b10) and the state encoding (IDLE=2'd0, LOAD_WAIT=2'd1, STORE_WAIT=2'd2, DONE=2'd3).
- One natural sub-module, mem_lane_align: purely combinational. Produces be and wdata replication from size/addr, and extracts load data with extension. The FSM, counter and handshake registers stay in the top module.

Test Plan:
- LW addr=0x100, dm_ack 3 cycles after dm_req with dm_rdata=0xDEADBEEF -> stall_load high 4 cycles (IDLE + 3 WAIT), DONE cycle rdata=0xDEADBEEF, rdata_valid=1, stall_load=0.
- LB addr=0x103, uns=0, dm_rdata=0x80123456 -> dm_be=4'b1000, rdata=0xFFFFFF80. Same access with LBU -> rdata=0x00000080.
- SH addr=0x202, wdata=0x0000ABCD, ack next cycle -> dm_we=1, dm_be=4'b1100, dm_wdata=0xABCDABCD, stall_store high 2 cycles, err=0.
- LW addr=0x101 -> no dm_req, err pulse 1 cycle, stall_load=0, rdata_valid=1 with rdata=0.
- Load with dm_ack never asserted, TIMEOUT=16 -> stall_load high 17 cycles, err=1 in DONE, rdata=0. A subsequent stray dm_ack in IDLE has no effect.
- rst_n pulled low during STORE_WAIT -> dm_req=0 and stall_store=0 immediately; after release, a new LW completes normally. Also: mem_read and mem_write high together -> only a read is issued (dm_we=0).
